// File: rtl/rotate_sequencer_pkg.sv
// Shared definitions for the rotate sequencer: default widths and FSM state encoding.
package rotate_sequencer_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rotate_sequencer_step.sv
// Combinational one-step rotator: rotates data by a single bit position.
module rotate_sequencer_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);

  // dir=1: right (bit i takes bit i+1, MSB takes bit 0); dir=0: left
  assign result = dir ? {data[0], data[WIDTH-1:1]}
                      : {data[WIDTH-2:0], data[WIDTH-1]};

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-cycle rotate: applies in_amount single-bit rotations, one per clock, then presents the result.
module rotate_sequencer
  import rotate_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             busy,
  output state_t           state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; out_data/out_zero
  // stay stable while out_valid && !out_ready.

  state_t           state, state_next;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] count;
  logic             dir_q;
  logic [WIDTH-1:0] step_out;

  rotate_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .data   (work),
    .dir    (dir_q),
    .result (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (in_amount != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (count == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter is only decremented in RUN, which is entered with a nonzero
  // amount and left when it reaches 1, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      count <= '0;
      dir_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            count <= in_amount;
            dir_q <= in_dir;
          end
        end
        RUN: begin
          work  <= step_out;
          count <= count - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;
  assign out_zero  = (work == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer: scoreboard of expected rotations, latency and handshake checks.
module tb_rotate_sequencer;
  import rotate_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amount;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       busy;
  state_t     state_dbg;

  logic [7:0] exp_q[$];
  int         errors;
  int         checks;

  rotate_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_rot(input logic [7:0] d, input int a, input logic dir);
    logic [15:0] w;
    logic [15:0] t;
    w = {d, d};
    if (dir) begin
      t = w >> a;
      return t[7:0];
    end else begin
      t = w << a;
      return t[15:8];
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b exp 1", tag, in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid got %b exp 0", tag, out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b exp 0", tag, busy); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL %s out_data got %h exp 00", tag, out_data); end
    checks++;
    if (out_zero !== 1'b1) begin errors++; $display("FAIL %s out_zero got %b exp 1", tag, out_zero); end
    checks++;
    if (state_dbg !== IDLE) begin errors++; $display("FAIL %s state got %0d exp IDLE", tag, state_dbg); end
    checks++;
  endtask

  // driver: one request, wait for result, optionally stall, then consume
  task automatic do_op(input logic [7:0] d, input int a, input logic dir,
                       input bit toggle, input int hold);
    int         cyc;
    logic [7:0] exp_d;
    logic [7:0] held;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b exp 1", in_ready); end
    checks++;
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = 3'(a);
    in_dir    = dir;
    exp_q.push_back(model_rot(d, a, dir));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_amount = 3'($urandom_range(0, 7));
    in_dir    = ~dir;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      if (toggle) in_data = ~in_data;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc != a + 1) begin errors++; $display("FAIL latency got %0d exp %0d", cyc, a + 1); end
    checks++;
    exp_d = exp_q.pop_front();
    if (out_data !== exp_d) begin errors++; $display("FAIL out_data got %h exp %h (in %h amt %0d dir %b)", out_data, exp_d, d, a, dir); end
    checks++;
    if (out_zero !== (exp_d == 8'h00)) begin errors++; $display("FAIL out_zero got %b exp %b", out_zero, exp_d == 8'h00); end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL done_flags in_ready %b busy %b exp 0 1", in_ready, busy); end
    checks++;
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d valid %b data %h ready %b exp 1 %h 0", i, out_valid, out_data, in_ready, held);
      end
      checks++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL consume valid %b ready %b busy %b exp 0 1 0", out_valid, in_ready, busy);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'hFF; in_amount = 3'd0; in_dir = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_release");
  endtask

  task automatic test_basic();
    do_op(8'h81, 1, 1'b0, 1'b0, 0);
    do_op(8'h81, 1, 1'b1, 1'b0, 0);
    do_op(8'h96, 3, 1'b0, 1'b0, 0);
    do_op(8'h96, 0, 1'b0, 1'b0, 0);
    do_op(8'h00, 4, 1'b1, 1'b0, 0);
    do_op(8'h01, 7, 1'b1, 1'b1, 0);
  endtask

  task automatic test_hold();
    do_op(8'h3C, 2, 1'b0, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_op(8'($urandom_range(0, 255)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_mid_run_reset();
    int seen;
    in_valid = 1'b1; in_data = 8'h5A; in_amount = 3'd5; in_dir = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    if (state_dbg !== RUN) begin errors++; $display("FAIL midrun_state got %0d exp RUN", state_dbg); end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    if (seen != 0) begin errors++; $display("FAIL discarded_result out_valid cycles got %0d exp 0", seen); end
    checks++;
  endtask

  task automatic test_first_accept();
    rst_n = 1'b0;
    #3;
    in_valid = 1'b1; in_data = 8'hA5; in_amount = 3'd0; in_dir = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL first_accept valid %b data %h exp 1 a5", out_valid, out_data);
    end
    checks++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_mid_run_reset();
    test_first_accept();
    do_op(8'hC3, 6, 1'b1, 1'b0, 1);
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", exp_q.size()); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
